// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared constants and state types for the UART command parser.
//   SYNC/ACK/NAK framing bytes, opcode values, parser FSM states and the
//   response-sender handshake phases.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] ACK_BYTE   = 8'h06;
    localparam logic [7:0] NAK_BYTE   = 8'h15;

    localparam logic [7:0] OP_WRITE   = 8'h01;
    localparam logic [7:0] OP_REFRESH = 8'h02;
    localparam logic [7:0] OP_PING    = 8'h03;

    typedef enum logic [3:0] {
        ST_SYNC,
        ST_OP,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_RESP,
        ST_RESP_WAIT
    } state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_REQ,
        TX_WAIT
    } tx_phase_t;

endpackage

// File: rtl/cmd_resp_sender.sv
// cmd_resp_sender: two-phase handshake toward the UART transmitter.
//   i_send            : one-cycle request, latches i_byte
//   i_byte            : response byte
//   i_is_transmitting : UART TX busy
//   o_transmit        : held high until the UART reports busy
//   o_tx_byte         : latched response byte, stable while o_transmit is high
//   o_done            : one-cycle pulse when the UART finishes the byte
module cmd_resp_sender
    import uart_cmd_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_send,
    input  logic [7:0] i_byte,
    input  logic       i_is_transmitting,
    output logic       o_transmit,
    output logic [7:0] o_tx_byte,
    output logic       o_done
);

    tx_phase_t  r_phase;
    tx_phase_t  w_phase_next;
    logic [7:0] r_tx_byte;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase   <= TX_IDLE;
            r_tx_byte <= 8'h00;
        end else begin
            r_phase <= w_phase_next;
            if (r_phase == TX_IDLE && i_send)
                r_tx_byte <= i_byte;
        end
    end

    always_comb begin
        w_phase_next = r_phase;
        o_done       = 1'b0;
        case (r_phase)
            TX_IDLE: if (i_send) w_phase_next = TX_REQ;
            TX_REQ:  if (i_is_transmitting) w_phase_next = TX_WAIT;
            TX_WAIT: begin
                if (!i_is_transmitting) begin
                    w_phase_next = TX_IDLE;
                    o_done       = 1'b1;
                end
            end
            default: w_phase_next = TX_IDLE;
        endcase
    end

    // Decoded straight from the phase register so reset drops it at once.
    assign o_transmit = (r_phase == TX_REQ);
    assign o_tx_byte  = r_tx_byte;

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: deframes A5/op/addr_hi/addr_lo/len/payload/chk packets from
// the UART receiver, streams WRITE payload into the framebuffer, issues panel
// refreshes and replies ACK/NAK through the UART transmitter.
//   clk, rst (async, active high)
//   received/rx_byte/recv_error : UART RX side
//   is_transmitting/transmit/tx_byte : UART TX side
//   wr_en/wr_addr/wr_data : framebuffer write port (registered)
//   refresh : one-cycle refresh request, busy : not in SYNC
//   err_count : saturating count of aborted or NAKed frames
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              received,
    input  logic [7:0]        rx_byte,
    input  logic              recv_error,
    input  logic              is_transmitting,
    output logic              transmit,
    output logic [7:0]        tx_byte,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              refresh,
    output logic              busy,
    output logic [7:0]        err_count
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_op;
    logic [7:0]         r_addr_hi;
    logic [ADDR_W-1:0]  r_addr;
    logic [7:0]         r_len;
    logic [7:0]         r_cnt;
    logic [7:0]         r_chk;
    logic [TMO_W-1:0]   r_tmo;
    logic [7:0]         r_err;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [7:0]         r_wr_data;
    logic               r_refresh;

    logic               w_in_frame;
    logic               w_timeout;
    logic               w_abort;
    logic               w_send;
    logic               w_ack;
    logic               w_op_ok;
    logic               w_done;

    assign w_in_frame = (r_state != ST_SYNC) && (r_state != ST_RESP) &&
                        (r_state != ST_RESP_WAIT);
    // An arriving byte beats an expiring timer.
    assign w_timeout  = w_in_frame && !received &&
                        (r_tmo == TMO_W'(TIMEOUT_CYCLES));
    assign w_op_ok    = (r_op == OP_WRITE) || (r_op == OP_PING) ||
                        (r_op == OP_REFRESH && r_len == 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_SYNC;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        w_send  = 1'b0;
        w_ack   = 1'b0;
        if (w_in_frame && (recv_error || w_timeout)) begin
            w_abort = 1'b1;
            w_next  = ST_SYNC;
        end else begin
            case (r_state)
                ST_SYNC:    if (received && rx_byte == SYNC_BYTE) w_next = ST_OP;
                ST_OP:      if (received) w_next = ST_ADDR_H;
                ST_ADDR_H:  if (received) w_next = ST_ADDR_L;
                ST_ADDR_L:  if (received) w_next = ST_LEN;
                ST_LEN:     if (received) w_next = (rx_byte == 8'd0) ? ST_CHK : ST_PAYLOAD;
                ST_PAYLOAD: if (received && r_cnt == 8'd1) w_next = ST_CHK;
                ST_CHK: begin
                    if (received) begin
                        w_send = 1'b1;
                        w_ack  = (r_chk == rx_byte) && w_op_ok;
                        w_next = ST_RESP;
                    end
                end
                // Mirrors the sender's own phases so busy/state stay aligned.
                ST_RESP:      if (is_transmitting) w_next = ST_RESP_WAIT;
                ST_RESP_WAIT: if (w_done) w_next = ST_SYNC;
                default:      w_next = ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= 8'h00;
            r_addr_hi <= 8'h00;
            r_addr    <= '0;
            r_len     <= 8'h00;
            r_cnt     <= 8'h00;
            r_chk     <= 8'h00;
            r_tmo     <= '0;
            r_err     <= 8'h00;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 8'h00;
            r_refresh <= 1'b0;
        end else begin
            r_wr_en   <= 1'b0;
            r_refresh <= 1'b0;

            if (!w_in_frame || received) r_tmo <= '0;
            else                         r_tmo <= r_tmo + TMO_W'(1);

            if ((w_abort || (w_send && !w_ack)) && r_err != 8'hFF)
                r_err <= r_err + 8'd1;

            if (received && !w_abort) begin
                case (r_state)
                    ST_SYNC:   r_chk <= 8'h00;
                    ST_OP: begin
                        r_op  <= rx_byte;
                        r_chk <= r_chk ^ rx_byte;
                    end
                    ST_ADDR_H: begin
                        r_addr_hi <= rx_byte;
                        r_chk     <= r_chk ^ rx_byte;
                    end
                    ST_ADDR_L: begin
                        r_addr <= ADDR_W'({r_addr_hi, rx_byte});
                        r_chk  <= r_chk ^ rx_byte;
                    end
                    ST_LEN: begin
                        r_len <= rx_byte;
                        r_cnt <= rx_byte;
                        r_chk <= r_chk ^ rx_byte;
                    end
                    ST_PAYLOAD: begin
                        r_chk <= r_chk ^ rx_byte;
                        r_cnt <= r_cnt - 8'd1;
                        // Written before the checksum is known; a bad chk only NAKs.
                        if (r_op == OP_WRITE) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_addr;
                            r_wr_data <= rx_byte;
                            r_addr    <= r_addr + ADDR_W'(1);
                        end
                    end
                    ST_CHK: if (w_ack && r_op == OP_REFRESH) r_refresh <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    cmd_resp_sender u_sender (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_send            (w_send),
        .i_byte            (w_ack ? ACK_BYTE : NAK_BYTE),
        .i_is_transmitting (is_transmitting),
        .o_transmit        (transmit),
        .o_tx_byte         (tx_byte),
        .o_done            (w_done)
    );

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign refresh   = r_refresh;
    assign busy      = (r_state != ST_SYNC);
    assign err_count = r_err;

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;
    import uart_cmd_pkg::*;

    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        received = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        recv_error = 1'b0;
    logic        is_transmitting = 1'b0;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        refresh;
    logic        busy;
    logic [7:0]  err_count;

    uart_cmd_parser #(.ADDR_W(16), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .received(received), .rx_byte(rx_byte),
        .recv_error(recv_error), .is_transmitting(is_transmitting),
        .transmit(transmit), .tx_byte(tx_byte), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .refresh(refresh),
        .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_err = 0;
    bit tx_stall = 1'b0;
    logic tx_prev = 1'b0;

    logic [23:0] wq[$];   // {addr, data}
    logic [8:0]  rq[$];   // {refresh, byte}
    logic [7:0]  pl_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Scoreboard monitor: writes and response starts pop expectations.
    always @(negedge clk) begin
        logic [23:0] e;
        logic [8:0]  r;
        if (wr_en) begin
            if (wq.size() == 0) chk("unexp_wr", {31'd0, wr_en}, 32'd0);
            else begin
                e = wq.pop_front();
                chk("wr_addr", {16'd0, wr_addr}, {16'd0, e[23:8]});
                chk("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
            end
        end
        if (transmit && !tx_prev) begin
            if (rq.size() == 0) chk("unexp_tx", {31'd0, transmit}, 32'd0);
            else begin
                r = rq.pop_front();
                chk("tx_byte", {24'd0, tx_byte}, {24'd0, r[7:0]});
                chk("refresh", {31'd0, refresh}, {31'd0, r[8]});
            end
        end else if (refresh) chk("stray_refresh", {31'd0, refresh}, 32'd0);
        tx_prev = transmit;
    end

    // UART TX model: accept after 2 cycles, busy for 5.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (rst || tx_stall) begin
                is_transmitting = 1'b0; cnt = 0;
            end else if (!is_transmitting && transmit) begin
                cnt++;
                if (cnt >= 2) begin is_transmitting = 1'b1; cnt = 0; end
            end else if (is_transmitting) begin
                cnt++;
                if (cnt >= 5) begin is_transmitting = 1'b0; cnt = 0; end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1; rx_byte = b; received = 1'b1;
        @(posedge clk); #1; received = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    // Sends a full frame with payload from pl_q; cmask corrupts the checksum.
    task automatic send_cmd(input logic [7:0] op, input logic [15:0] addr,
                            input logic [7:0] len, input logic [7:0] cmask);
        logic [7:0] c;
        c = op ^ addr[15:8] ^ addr[7:0] ^ len;
        send_byte(SYNC_BYTE); send_byte(op);
        send_byte(addr[15:8]); send_byte(addr[7:0]); send_byte(len);
        foreach (pl_q[i]) begin send_byte(pl_q[i]); c ^= pl_q[i]; end
        send_byte(c ^ cmask);
    endtask

    task automatic push_writes(input logic [15:0] addr);
        logic [15:0] a;
        a = addr;
        foreach (pl_q[i]) begin wq.push_back({a, pl_q[i]}); a = a + 16'd1; end
    endtask

    task automatic push_resp(input logic [7:0] b, input logic rf);
        rq.push_back({rf, b});
        if (b == NAK_BYTE) bump_err();
    endtask

    task automatic bump_err();
        if (exp_err < 255) exp_err++;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 300 && busy; k++) @(negedge clk);
        @(negedge clk);
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_wq"}, wq.size(), 32'd0);
        chk({tag, "_rq"}, rq.size(), 32'd0);
        chk({tag, "_err"}, {24'd0, err_count}, exp_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_transmit", {31'd0, transmit}, 32'd0);
        chk("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {24'd0, err_count}, 32'd0);
        chk("rst_refresh", {31'd0, refresh}, 32'd0);

        // WRITE of three bytes, good checksum.
        pl_q.delete(); pl_q.push_back(8'hAA); pl_q.push_back(8'hBB); pl_q.push_back(8'hCC);
        push_writes(16'h1234); push_resp(ACK_BYTE, 1'b0);
        send_cmd(OP_WRITE, 16'h1234, 8'd3, 8'h00);
        wait_idle("idle_wr"); check_drained("wr");

        // WRITE wrapping the address, bad checksum.
        pl_q.delete(); pl_q.push_back(8'h11); pl_q.push_back(8'h22);
        push_writes(16'hFFFF); push_resp(NAK_BYTE, 1'b0);
        send_cmd(OP_WRITE, 16'hFFFF, 8'd2, 8'h5A);
        wait_idle("idle_wrap"); check_drained("wrap");

        // REFRESH, len 0: refresh with the ACK.
        pl_q.delete();
        push_resp(ACK_BYTE, 1'b1);
        send_cmd(OP_REFRESH, 16'h0000, 8'd0, 8'h00);
        wait_idle("idle_ref"); check_drained("ref");

        // REFRESH with len 1: consumed, NAKed, no refresh or write.
        pl_q.delete(); pl_q.push_back(8'h77);
        push_resp(NAK_BYTE, 1'b0);
        send_cmd(OP_REFRESH, 16'h0000, 8'd1, 8'h00);
        wait_idle("idle_ref1"); check_drained("ref1");

        // Unknown opcode: NAK.
        pl_q.delete();
        push_resp(NAK_BYTE, 1'b0);
        send_cmd(8'h09, 16'h0102, 8'd0, 8'h00);
        wait_idle("idle_unk"); check_drained("unk");

        // Stall mid-payload past the timeout.
        wq.push_back({16'h0000, 8'h11});
        send_byte(SYNC_BYTE); send_byte(OP_WRITE); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h04); send_byte(8'h11);
        repeat (TMO + 20) @(posedge clk);
        bump_err();
        wait_idle("idle_tmo"); check_drained("tmo");

        // PING after timeout.
        pl_q.delete();
        push_resp(ACK_BYTE, 1'b0);
        send_cmd(OP_PING, 16'h0000, 8'd0, 8'h00);
        wait_idle("idle_ping"); check_drained("ping");

        // Leading garbage then PING.
        send_byte(8'h00); send_byte(8'hFF);
        chk("garbage_busy", {31'd0, busy}, 32'd0);
        push_resp(ACK_BYTE, 1'b0);
        send_cmd(OP_PING, 16'hBEEF, 8'd0, 8'h00);
        wait_idle("idle_garb"); check_drained("garb");

        // recv_error mid-payload: abort, no response.
        wq.push_back({16'h0010, 8'hAA});
        send_byte(SYNC_BYTE); send_byte(OP_WRITE); send_byte(8'h00);
        send_byte(8'h10); send_byte(8'h03); send_byte(8'hAA);
        @(posedge clk); #1 recv_error = 1'b1;
        @(posedge clk); #1 recv_error = 1'b0;
        bump_err();
        repeat (20) @(posedge clk);
        wait_idle("idle_rerr"); check_drained("rerr");

        // Reset while transmit is held high.
        tx_stall = 1'b1;
        push_resp(ACK_BYTE, 1'b0);
        send_cmd(OP_PING, 16'h0000, 8'd0, 8'h00);
        for (int k = 0; k < 100 && !transmit; k++) @(negedge clk);
        chk("tx_held", {31'd0, transmit}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_transmit", {31'd0, transmit}, 32'd0);
        chk("arst_tx_byte", {24'd0, tx_byte}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_err", {24'd0, err_count}, 32'd0);
        exp_err = 0;
        @(posedge clk); #1 rst = 1'b0; tx_stall = 1'b0;
        repeat (3) @(posedge clk);
        check_drained("arst");

        // 260 bad frames: saturation.
        pl_q.delete();
        for (int f = 0; f < 260; f++) begin
            push_resp(NAK_BYTE, 1'b0);
            send_cmd(OP_PING, 16'h0000, 8'd0, 8'hFF);
            wait_idle("idle_sat");
        end
        check_drained("sat");
        chk("err_sat", {24'd0, err_count}, 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-stream command decoder sitting directly downstream of the `uart` receiver and driving its transmitter for replies. It consumes `received`/`rx_byte` pulses, deframes host packets, and streams WRITE payload into the e-ink framebuffer write port. It also issues refresh requests and returns a one-byte ACK/NAK per frame through the UART `transmit`/`tx_byte` handshake.

## Interface
Parameters:
- `ADDR_W`, default 16: framebuffer byte-address width.
- `TIMEOUT_CYCLES`, default 1000000: inter-byte timeout in `clk` cycles.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  master clock, shared with `uart`.
- `rst`  in  1  asynchronous, active-high reset.
- `received`  in  1  one-cycle pulse from UART RX; `rx_byte` is valid.
- `rx_byte`  in  8  received byte.
- `recv_error`  in  1  one-cycle UART framing-error pulse.
- `is_transmitting`  in  1  UART TX busy.
- `transmit`  out  1  request to UART TX; held until accepted.
- `tx_byte`  out  8  response byte, stable while `transmit` is high.
- `wr_en`  out  1  one-cycle framebuffer write strobe.
- `wr_addr`  out  ADDR_W  write address.
- `wr_data`  out  8  write data.
- `refresh`  out  1  one-cycle panel-refresh request.
- `busy`  out  1  high in any state other than SYNC.
- `err_count`  out  8  saturating count of aborted or NAKed frames.

## Operation
- Frame format: 0xA5 sync, opcode, addr_hi, addr_lo, len, len payload bytes, chk.
  - `len` = 0 means no payload.
  - chk = XOR of opcode through the last payload byte.
- Opcodes:
  - 0x01 WRITE: payload byte i is written to (addr + i) mod 2^ADDR_W.
  - 0x02 REFRESH: requires len = 0.
  - 0x03 PING: no side effect.
- States: SYNC, OP, ADDR_H, ADDR_L, LEN, PAYLOAD, CHK, RESP, RESP_WAIT. Each transition advances on a `received` pulse, except RESP and RESP_WAIT.
- SYNC: any byte other than 0xA5 is silently discarded.
- LEN: len = 0 goes to CHK; otherwise goes to PAYLOAD.
- PAYLOAD: after the len-th byte, go to CHK.
- WRITE payload is written as it arrives, before the checksum is known. A checksum failure does not undo writes; it only yields a NAK.
- Unknown opcode, or REFRESH with len ≠ 0: the frame is still consumed to CHK, then NAKed. No writes and no refresh occur.
- CHK:
  - Match and valid opcode: tx_byte = 0x06 (ACK); if REFRESH, pulse `refresh`.
  - Otherwise: tx_byte = 0x15 (NAK) and `err_count`++.
  - Then go to RESP.
- RESP: hold `transmit` = 1 until `is_transmitting` = 1, then go to RESP_WAIT.
- RESP_WAIT: `transmit` = 0; wait for `is_transmitting` = 0, then go to SYNC.
- Bytes received in RESP or RESP_WAIT are dropped.
- Abort, with no response, `err_count`++, and return to SYNC:
  - `recv_error` in any state from OP through CHK.
  - Timeout counter reaching TIMEOUT_CYCLES in any state from OP through CHK.
- `err_count` saturates at 255.

## Timing
- Reset values: all outputs 0, `tx_byte` = 0x00, state SYNC, timeout counter 0.
- Reset mid-frame or mid-response drops `transmit` immediately. The frame is lost.
- `wr_en`, `wr_addr` and `wr_data` are registered: `received` at cycle N gives `wr_en` at N+1. `wr_en` is never high on two consecutive cycles, since UART bytes are ≥ 1 bit-period apart.
- `refresh` pulses at N+1 after the chk byte's `received` at cycle N, in the same cycle that `transmit` rises.
- Timeout counter:
  - Cleared on every `received` pulse and in SYNC/RESP/RESP_WAIT.
  - Otherwise increments by 1 per cycle.
  - Compares with == TIMEOUT_CYCLES, and is sized to hold that value.
- Simultaneous `received` and `recv_error`: the error wins.
- Simultaneous `received` and timeout expiry: the byte wins and the counter clears.
- Address arithmetic is ADDR_W bits and wraps from 2^ADDR_W−1 to 0 within one frame.
- Payload counter is 8 bits, loaded with len and decremented per byte; the frame leaves PAYLOAD when it reaches 0.

## Structure
- Shared package `uart_cmd_pkg`:
  - SYNC_BYTE, ACK_BYTE, NAK_BYTE.
  - Opcode constants.
  - State enumeration.
- Sub-module `cmd_resp_sender`: owns the `transmit`/`is_transmitting` two-phase handshake (RESP/RESP_WAIT). Its inputs are `send` and `byte`; its output is `done`.
- Checksum, timeout and address logic stay inline in `uart_cmd_parser`.

## Test plan
- Send A5 01 12 34 03 AA BB CC chk = 01^12^34^03^AA^BB^CC:
  - Three `wr_en` pulses at 0x1234/AA, 0x1235/BB, 0x1236/CC.
  - ACK 0x06 is transmitted.
- Send A5 01 FF FF 02 11 22 with a bad chk:
  - Writes go to 0xFFFF then 0x0000.
  - NAK 0x15 is transmitted; `err_count` = 1.
- Send A5 02 00 00 00 02:
  - One `refresh` pulse coincident with `transmit` rising; ACK.
  - Same frame with len = 1: no refresh; NAK.
- Send A5 01 00 00 04 11, then stall longer than TIMEOUT_CYCLES:
  - Return to SYNC, no `transmit`, `err_count`++.
  - A following PING frame is ACKed.
- Leading garbage 00 FF then a PING: ACK, with `err_count` unchanged.
- Pulse `recv_error` mid-payload: abort, no response.
- Assert `rst` while `transmit` is high: all outputs return to 0 asynchronously.
- Send 260 bad frames: `err_count` holds at 255.
